// File: rtl/gpmc_csr_bank_pkg.sv
`default_nettype none
// ============================================================================
// Module      : csr_pkg
// Description : Register map offsets, ID default and decode helper for the
//               GPMC CSR bank.
// Revision    : 1.0
// ============================================================================
package csr_pkg;

  localparam logic [15:0] c_ID_DEFAULT = 16'hC10D;
  localparam logic [15:0] c_CNT_MAX    = 16'hFFFF;

  // Byte offsets from BASE_ADDR (bit 0 always cleared before decode)
  localparam logic [5:0] c_OFS_ID      = 6'h00;
  localparam logic [5:0] c_OFS_STATUS  = 6'h02;
  localparam logic [5:0] c_OFS_CLEAR   = 6'h04;
  localparam logic [5:0] c_OFS_CONTROL = 6'h06;
  localparam logic [5:0] c_OFS_PULSE   = 6'h08;
  localparam logic [5:0] c_OFS_SCRATCH = 6'h10;
  localparam logic [5:0] c_OFS_EVCNT   = 6'h20;

  typedef enum logic [2:0] {
    SEL_NONE    = 3'd0,
    SEL_ID      = 3'd1,
    SEL_STATUS  = 3'd2,
    SEL_CLEAR   = 3'd3,
    SEL_CONTROL = 3'd4,
    SEL_PULSE   = 3'd5,
    SEL_SCRATCH = 3'd6,
    SEL_EVCNT   = 3'd7
  } csr_sel_e;

  function automatic csr_sel_e csr_decode(input logic [5:0] ofs);
    csr_sel_e sel;
    sel = SEL_NONE;
    if (ofs[5]) begin
      sel = SEL_EVCNT;
    end else if (ofs[4]) begin
      sel = SEL_SCRATCH;
    end else begin
      case (ofs)
        c_OFS_ID:      sel = SEL_ID;
        c_OFS_STATUS:  sel = SEL_STATUS;
        c_OFS_CLEAR:   sel = SEL_CLEAR;
        c_OFS_CONTROL: sel = SEL_CONTROL;
        c_OFS_PULSE:   sel = SEL_PULSE;
        default:       sel = SEL_NONE;
      endcase
    end
    return sel;
  endfunction

endpackage
`default_nettype wire

// File: rtl/gpmc_csr_bank_if.sv
`default_nettype none
// ============================================================================
// Module      : gpmc_csr_bank_if
// Description : GPMC register bus, event inputs and control outputs.
// Revision    : 1.0
// ============================================================================
interface gpmc_csr_bank_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int NUM_EVENTS = 8
);

  logic                  address_valid;
  logic [ADDR_WIDTH-1:0] address;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [NUM_EVENTS-1:0] events;
  logic [DATA_WIDTH-1:0] ctrl;
  logic [DATA_WIDTH-1:0] ctrl_pulse;

  modport master (
    output address_valid, address, wr_en, wr_data, events,
    input  rd_data, ctrl, ctrl_pulse
  );

  modport slave (
    input  address_valid, address, wr_en, wr_data, events,
    output rd_data, ctrl, ctrl_pulse
  );

endinterface
`default_nettype wire

// File: rtl/gpmc_csr_bank_event_latch.sv
`default_nettype none
// ============================================================================
// Module      : csr_event_latch
// Description : Sticky status bit for one event, plus an optional 16-bit
//               saturating counter when CSR_EVENT_CNT_EN is defined.
// Revision    : 1.0
// ============================================================================
module csr_event_latch
  import csr_pkg::*;
(
  input  wire logic        clk,
  input  wire logic        reset,
  input  wire logic        i_event,
  input  wire logic        i_clear,
  output logic             o_sticky
`ifdef CSR_EVENT_CNT_EN
  ,
  output logic [15:0]      o_count
`endif
);

  logic r_sticky;

  // Set has priority so an event coincident with a clear is never lost
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sticky <= 1'b0;
    end else if (i_event) begin
      r_sticky <= 1'b1;
    end else if (i_clear) begin
      r_sticky <= 1'b0;
    end
  end

  assign o_sticky = r_sticky;

`ifdef CSR_EVENT_CNT_EN
  logic [15:0] r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= {15'd0, i_event};
    end else if (i_event && (r_count != c_CNT_MAX)) begin
      r_count <= r_count + 16'd1;
    end
  end

  assign o_count = r_count;
`endif

endmodule
`default_nettype wire

// File: rtl/gpmc_csr_bank.sv
`default_nettype none
// ============================================================================
// Module      : gpmc_csr_bank
// Description : GPMC-attached CSR bank: ID, sticky STATUS/CLEAR, CONTROL,
//               PULSE and scratch registers; per-event counters are built
//               only when CSR_EVENT_CNT_EN is defined.
// Revision    : 1.0
// ============================================================================
module gpmc_csr_bank
  import csr_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 16,
  parameter int                    DATA_WIDTH  = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter logic [15:0]           ID_VALUE    = c_ID_DEFAULT,
  parameter int                    NUM_SCRATCH = 4,
  parameter int                    NUM_EVENTS  = 8
) (
  input wire logic       clk,
  input wire logic       reset,
  gpmc_csr_bank_if.slave bus
);

  logic [ADDR_WIDTH-1:0] w_offset_full;
  logic                  w_hit;
  logic [5:0]            w_ofs;
  logic                  w_unused_ofs_lsb;
  csr_sel_e              w_sel;
  logic                  w_wr;
  logic [NUM_EVENTS-1:0] w_clear;
  logic [NUM_EVENTS-1:0] w_status;
  logic [DATA_WIDTH-1:0] w_status_ext;
  logic [DATA_WIDTH-1:0] w_rd_next;
`ifdef CSR_EVENT_CNT_EN
  logic [15:0]           w_evcnt [NUM_EVENTS];
`endif

  logic [DATA_WIDTH-1:0] r_rd_data;
  logic [DATA_WIDTH-1:0] r_ctrl;
  logic [DATA_WIDTH-1:0] r_pulse;
  logic [DATA_WIDTH-1:0] r_scratch [NUM_SCRATCH];

  // Unsigned subtraction wraps addresses below the base out of range too
  assign w_offset_full    = bus.address - {BASE_ADDR[ADDR_WIDTH-1:1], 1'b0};
  assign w_hit            = (w_offset_full[ADDR_WIDTH-1:6] == '0);
  assign w_ofs            = {w_offset_full[5:1], 1'b0};
  assign w_unused_ofs_lsb = w_offset_full[0];
  assign w_sel            = w_hit ? csr_decode(w_ofs) : SEL_NONE;
  assign w_wr             = bus.wr_en & ~reset;

  assign w_clear      = (w_wr && (w_sel == SEL_CLEAR)) ? bus.wr_data[NUM_EVENTS-1:0] : '0;
  assign w_status_ext = DATA_WIDTH'(w_status);

  for (genvar gi = 0; gi < NUM_EVENTS; gi++) begin : g_event
    csr_event_latch u_latch (
      .clk      (clk),
      .reset    (reset),
      .i_event  (bus.events[gi]),
      .i_clear  (w_clear[gi]),
      .o_sticky (w_status[gi])
`ifdef CSR_EVENT_CNT_EN
      ,
      .o_count  (w_evcnt[gi])
`endif
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ctrl    <= '0;
      r_pulse   <= '0;
      r_rd_data <= '0;
    end else begin
      r_pulse   <= (w_wr && (w_sel == SEL_PULSE)) ? bus.wr_data : '0;
      r_rd_data <= bus.address_valid ? w_rd_next : '0;
      if (w_wr && (w_sel == SEL_CONTROL)) begin
        r_ctrl <= bus.wr_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_SCRATCH; k++) begin
      if (reset) begin
        r_scratch[k] <= '0;
      end else if (w_wr && (w_sel == SEL_SCRATCH) && (int'(w_ofs[3:1]) == k)) begin
        r_scratch[k] <= bus.wr_data;
      end
    end
  end

  // Indices beyond the implemented scratch/counter count fall through to 0
  always_comb begin
    w_rd_next = '0;
    case (w_sel)
      SEL_ID:      w_rd_next = DATA_WIDTH'(ID_VALUE);
      SEL_STATUS:  w_rd_next = w_status_ext;
      SEL_CONTROL: w_rd_next = r_ctrl;
      SEL_SCRATCH: begin
        for (int k = 0; k < NUM_SCRATCH; k++) begin
          if (int'(w_ofs[3:1]) == k) begin
            w_rd_next = r_scratch[k];
          end
        end
      end
`ifdef CSR_EVENT_CNT_EN
      SEL_EVCNT: begin
        for (int k = 0; k < NUM_EVENTS; k++) begin
          if (int'(w_ofs[4:1]) == k) begin
            w_rd_next = DATA_WIDTH'(w_evcnt[k]);
          end
        end
      end
`endif
      default:     w_rd_next = '0;
    endcase
  end

  assign bus.rd_data    = r_rd_data;
  assign bus.ctrl       = r_ctrl;
  assign bus.ctrl_pulse = r_pulse;

endmodule
`default_nettype wire

// File: doc/gpmc_csr_bank.md
GPMC_CSR_BANK -- requirements
Module: gpmc_csr_bank

Interface
REQ-001 Parameter ADDR_WIDTH, default 16: width of the GPMC address.
REQ-002 Parameter DATA_WIDTH, default 16: width of the register data, 16 or 32.
REQ-003 Parameter BASE_ADDR, default 16'h0000: byte base of the bank; bank spans BASE_ADDR..BASE_ADDR+16'h3F.
REQ-004 Parameter ID_VALUE, default 16'hC10D: constant returned by the ID register.
REQ-005 Parameter NUM_SCRATCH, default 4: number of RW scratch registers, 1..8.
REQ-006 Parameter NUM_EVENTS, default 8: number of event inputs, 1..DATA_WIDTH.
REQ-007 Port clk, input, 1: the only clock.
REQ-008 Port reset, input, 1: reset is synchronous and active-high.
REQ-009 Port address_valid, input, 1: the address is valid for a read.
REQ-010 Port address, input, ADDR_WIDTH: byte address; bit 0 is ignored.
REQ-011 Port wr_en, input, 1: single-cycle write strobe qualified by address.
REQ-012 Port wr_data, input, DATA_WIDTH: write data.
REQ-013 Port rd_data, output, DATA_WIDTH: registered read data; zero when not selected, so it can be OR-combined on the shared bus.
REQ-014 Port events, input, NUM_EVENTS: single-cycle event pulses (overflow, underflow, etc.).
REQ-015 Port ctrl, output, DATA_WIDTH: CONTROL register contents.
REQ-016 Port ctrl_pulse, output, DATA_WIDTH: one-cycle pulses from the PULSE register.

Function
REQ-017 The register map SHALL use these offsets from BASE_ADDR: +0x00 ID (RO); +0x02 STATUS, sticky event bits (RO); +0x04 CLEAR (WO, write-1-to-clear, reads 0); +0x06 CONTROL (RW); +0x08 PULSE (WO, reads 0); +0x10+2n SCRATCHn (RW); +0x20+2n EVCNTn (RO, only when the macro is defined).
REQ-018 Read latency SHALL be one cycle: rd_data in cycle N+1 reflects address and register state at cycle N when address_valid=1.
REQ-019 rd_data SHALL be 0 in cycle N+1 when address_valid=0 or the address is unmapped in cycle N.
REQ-020 A write SHALL take effect on the clock edge where wr_en=1; wr_en with an unmapped or RO address SHALL be ignored.
REQ-021 STATUS bit i SHALL set on the cycle after events[i]=1 and hold until a CLEAR write with bit i=1.
REQ-022 When events[i] and a clear of bit i occur in the same cycle, set SHALL win and no event is lost.
REQ-023 A PULSE write SHALL drive ctrl_pulse=wr_data for exactly one cycle and 0 otherwise; back-to-back writes give back-to-back pulses.
REQ-024 Reads of SCRATCHn or EVCNTn with n at or above NUM_SCRATCH or NUM_EVENTS SHALL return 0.
REQ-025 Unused upper STATUS bits SHALL read 0.

Reset
REQ-026 Reset SHALL clear rd_data, STATUS, CONTROL, ctrl_pulse, SCRATCHn and EVCNTn to 0.
REQ-027 Events, writes and reads SHALL be ignored while reset=1.
REQ-028 Reset asserted mid-operation SHALL override a same-cycle write.

Configuration
REQ-029 When CSR_EVENT_CNT_EN is defined, each event SHALL have a 16-bit saturating counter EVCNTn that increments per events[n] pulse, sticks at 16'hFFFF and clears with the same CLEAR bit.
REQ-030 When a counter is cleared and incremented in the same cycle, its value SHALL become 1.
REQ-031 When CSR_EVENT_CNT_EN is undefined, there SHALL be no counter logic and the 0x20 range SHALL read 0.

Structure
REQ-032 Register offset localparams and the ID default SHALL live in package csr_pkg.
REQ-033 The per-event sticky bit and optional counter SHALL be sub-module csr_event_latch, instantiated NUM_EVENTS times.

Verification
REQ-034 Read ID: address_valid=1 at BASE+0 -> rd_data=16'hC10D next cycle, then 0 once address_valid drops.
REQ-035 Scratch write then read: write 16'hBEEF to SCRATCH2 -> read returns 16'hBEEF; SCRATCH7 with NUM_SCRATCH=4 returns 0.
REQ-036 Sticky event: pulse events[4] -> STATUS=16'h0010; CLEAR with 16'h0010 in the same cycle as events[4] -> STATUS stays 16'h0010.
REQ-037 PULSE: write 16'h0005 -> ctrl_pulse=16'h0005 for one cycle, then 0.
REQ-038 Counters (CSR_EVENT_CNT_EN): 70000 pulses on events[0] -> EVCNT0=16'hFFFF; clear+event in one cycle -> 1.
REQ-039 Reset mid-write: reset=1 with a CONTROL write of 16'h00FF -> CONTROL=0 and all reads 0.
